// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin arbiter sharing one WIDTH-bit register among NREQ writers
// A locked owner keeps the grant for at most HOLD_MAX consecutive cycles.
module dff_bank_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4,
    parameter int IW       = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic [IW-1:0]         owner,
    output logic                  valid
);

    localparam int HC_W = $clog2(HOLD_MAX) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [WIDTH-1:0]  q_q;
    logic [IW-1:0]     owner_q;
    logic              valid_q;
    logic [IW-1:0]     ptr_q;
    logic [HC_W-1:0]   hold_cnt_q;

    logic              win_found;
    logic [IW-1:0]     win_idx;
    logic [NREQ-1:0]   gnt_d;
    logic [IW-1:0]     ptr_d;
    logic              hold_ok;
    logic [WIDTH-1:0]  win_data;
    logic [WIDTH-1:0]  own_data;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % NREQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end

        gnt_d          = '0;
        gnt_d[win_idx] = 1'b1;
        ptr_d          = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

        win_data = wdata[int'(win_idx) * WIDTH +: WIDTH];
        own_data = wdata[int'(owner_q) * WIDTH +: WIDTH];

        // Hitting the limit forces re-arbitration even if the owner still locks.
        hold_ok = (state_q == GRANT) && req[owner_q] && lock[owner_q] &&
                  (hold_cnt_q < HC_W'(HOLD_MAX - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            q_q        <= '0;
            owner_q    <= '0;
            valid_q    <= 1'b0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else if (hold_ok) begin
            q_q        <= own_data;
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end else if (win_found) begin
            state_q    <= GRANT;
            gnt_q      <= gnt_d;
            q_q        <= win_data;
            owner_q    <= win_idx;
            valid_q    <= 1'b1;
            ptr_q      <= ptr_d;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            hold_cnt_q <= '0;
        end
    end

    assign gnt   = gnt_q;
    assign q     = q_q;
    assign owner = owner_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - vector table plus scoreboard bench for dff_bank_arbiter
module tb_dff_bank_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        valid;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic [1:0]  owner;
        logic        valid;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    localparam logic [31:0] WD = 32'hA3A2A1A0;

    dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_MAX(4)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
        .gnt(gnt), .q(q), .owner(owner), .valid(valid)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] l, input logic [31:0] w,
                                input logic [3:0] g, input logic [7:0] qq, input logic [1:0] o,
                                input logic v);
        vec_t t;
        t.req = r; t.lock = l; t.wdata = w; t.gnt = g; t.q = qq; t.owner = o; t.valid = v;
        return t;
    endfunction

    task automatic check_now(input string name, input logic [3:0] eg, input logic [7:0] eq,
                             input logic [1:0] eo, input logic ev);
        tests++;
        if (gnt !== eg || q !== eq || owner !== eo || valid !== ev) begin
            failed++;
            $display("FAIL %s: got gnt=%b q=%h owner=%0d valid=%b, want gnt=%b q=%h owner=%0d valid=%b",
                     name, gnt, q, owner, valid, eg, eq, eo, ev);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        vec_t e;
        req = v.req; lock = v.lock; wdata = v.wdata;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++; failed++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check_now(name, e.gnt, e.q, e.owner, e.valid);
        end
    endtask

    initial begin
        // Round-robin from ptr=0 straight out of reset.
        vecs.push_back(mk(4'b1111, 4'b0000, WD, 4'b0001, 8'hA0, 2'd0, 1'b1));
        vecs.push_back(mk(4'b1111, 4'b0000, WD, 4'b0010, 8'hA1, 2'd1, 1'b1));
        vecs.push_back(mk(4'b1111, 4'b0000, WD, 4'b0100, 8'hA2, 2'd2, 1'b1));
        vecs.push_back(mk(4'b1111, 4'b0000, WD, 4'b1000, 8'hA3, 2'd3, 1'b1));
        vecs.push_back(mk(4'b1111, 4'b0000, WD, 4'b0001, 8'hA0, 2'd0, 1'b1));
        // Lock limit: 1 wins once, 0 holds four cycles with changing data, then 1, then 0.
        vecs.push_back(mk(4'b0000, 4'b0000, WD, 4'b0000, 8'hA0, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0011, 4'b0001, WD, 4'b0010, 8'hA1, 2'd1, 1'b1));
        vecs.push_back(mk(4'b0011, 4'b0001, WD, 4'b0001, 8'hA0, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0011, 4'b0001, 32'hA3A2A1B0, 4'b0001, 8'hB0, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0011, 4'b0001, 32'hA3A2A1B1, 4'b0001, 8'hB1, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0011, 4'b0001, 32'hA3A2A1B2, 4'b0001, 8'hB2, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0011, 4'b0001, WD, 4'b0010, 8'hA1, 2'd1, 1'b1));
        vecs.push_back(mk(4'b0011, 4'b0001, WD, 4'b0001, 8'hA0, 2'd0, 1'b1));
        // Sparse and wrap past index 3; non-owner lock ignored.
        vecs.push_back(mk(4'b0100, 4'b0000, WD, 4'b0100, 8'hA2, 2'd2, 1'b1));
        vecs.push_back(mk(4'b0101, 4'b0000, WD, 4'b0001, 8'hA0, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0101, 4'b0100, WD, 4'b0100, 8'hA2, 2'd2, 1'b1));
        vecs.push_back(mk(4'b0101, 4'b0000, WD, 4'b0001, 8'hA0, 2'd0, 1'b1));
        // Idle hold: q keeps 5C while wdata churns.
        vecs.push_back(mk(4'b0010, 4'b0000, 32'hA3A25CA0, 4'b0010, 8'h5C, 2'd1, 1'b1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(4'b0000, 4'b0000, 32'hFFFFFFFF, 4'b0000, 8'h5C, 2'd1, 1'b1));
        // Owner dropping req while locked loses the grant at the next edge.
        vecs.push_back(mk(4'b1000, 4'b1000, WD, 4'b1000, 8'hA3, 2'd3, 1'b1));
        vecs.push_back(mk(4'b1000, 4'b1000, WD, 4'b1000, 8'hA3, 2'd3, 1'b1));
        vecs.push_back(mk(4'b0001, 4'b1000, WD, 4'b0001, 8'hA0, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0001, 4'b0001, WD, 4'b0001, 8'hA0, 2'd0, 1'b1));

        reset = 1'b1; req = 4'b1111; lock = 4'b0000; wdata = WD;
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_hold", 4'b0000, 8'h00, 2'd0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], $sformatf("vec%0d", i));

        // Owner 0 is mid-lock; reset between edges must clear outputs without a clock.
        #2;
        reset = 1'b1;
        #1;
        check_now("async_reset", 4'b0000, 8'h00, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(mk(4'b1111, 4'b0000, WD, 4'b0001, 8'hA0, 2'd0, 1'b1), "post_reset0");
        step(mk(4'b0110, 4'b0000, WD, 4'b0010, 8'hA1, 2'd1, 1'b1), "post_reset1");

        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin arbiter that shares one WIDTH-bit D-flip-flop register among NREQ requesters. Each cycle it grants at most one requester and loads that requester's data into the shared register. A granted requester may lock ownership for back-to-back writes, bounded by HOLD_MAX cycles. The block sits between client write ports and the shared register; downstream logic reads q and owner.

## Interface
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, register data width
- HOLD_MAX, 4, maximum consecutive cycles one owner may hold the grant (>=1)
- IW, derived, $clog2(NREQ), owner index width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req  input  NREQ  per-requester write request, level-sensitive
- lock  input  NREQ  per-requester hold request; only meaningful for the current owner
- wdata  input  NREQ*WIDTH  packed write data; slice i = wdata[i*WIDTH +: WIDTH]
- gnt  output  NREQ  registered one-hot grant; all-zero when idle
- q  output  WIDTH  shared register contents
- owner  output  IW  index of the requester that last wrote q
- valid  output  1  sticky; high once q has been written since reset

## Operation
- States: IDLE (gnt == 0) and GRANT (gnt one-hot). Internal registers: ptr (IW bits, round-robin start), hold_cnt ($clog2(HOLD_MAX)+1 bits).
- Hold condition, evaluated each edge in GRANT: req[owner] & lock[owner] & (hold_cnt < HOLD_MAX-1).
  - True: gnt unchanged; q <= wdata[owner]; hold_cnt <= hold_cnt+1; ptr unchanged.
- Arbitration, evaluated each edge where the hold condition is false, including every edge in IDLE:
  - Winner w = first index with req set, scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - If a winner exists: gnt <= onehot(w); q <= wdata[w]; owner <= w; ptr <= (w+1) mod NREQ; hold_cnt <= 0; valid <= 1.
  - If no req is set: gnt <= 0; q, owner, ptr and valid hold; hold_cnt <= 0.
- Releasing owner: when the hold limit is reached, ptr already points past the owner. If the owner still requests, it is scanned last and wins only if no other requester is active.
- Release without a bubble: the hold condition going false in GRANT re-arbitrates on the same edge, so there are no idle cycles between owners.
- q changes only on an edge where gnt is non-zero after the edge; it keeps its last value in IDLE.
- Dropping req: when the owner drops req (with or without lock), ownership ends at the next edge.
- lock from non-owners is ignored.

## Timing
- Reset values: gnt=0, q=0, owner=0, valid=0, ptr=0, hold_cnt=0; state IDLE.
- Reset asserted mid-grant forces these values within the same cycle, without waiting for clk. The first edge after reset deasserts performs normal arbitration from ptr=0.
- Latency: req sampled at edge k produces gnt and updated q visible after edge k. q and gnt change on the same edge.
- Throughput: one register write per cycle while any req is active.
- Maximum continuous ownership: HOLD_MAX cycles. With HOLD_MAX=1, lock has no effect.
- Wrap-around: ptr increments modulo NREQ. Index NREQ-1 winning sets ptr=0.
- Requester handshake: a requester must keep req high and wdata stable until it sees its gnt bit high after an edge. Each cycle with its gnt bit high is one write.
- Simultaneous req and lock on the owner at the limit: release takes priority.

## Test plan
- Reset: hold reset high, toggle req=4'b1111 -> gnt=0, q=0, valid=0. Release reset with req=4'b1111 -> first edge gives gnt=4'b0001, owner=0.
- Round-robin: req=4'b1111, lock=0, wdata slices 8'hA0..8'hA3 -> gnt cycles 0001, 0010, 0100, 1000, 0001; q follows A0, A1, A2, A3, A0 with no idle cycles.
- Lock limit: HOLD_MAX=4, req=4'b0011, lock=4'b0001 -> gnt=0001 for 4 cycles, then 0010. Requester 1 without lock gets 1 cycle, then requester 0 regains the grant.
- Sparse and wrap: ptr=3 after a grant to 2, req=4'b0101 -> next grant to 0 (wrap past 3), then 2.
- Idle hold: grant requester 1 with wdata=8'h5C, then req=0 for 5 cycles -> gnt=0, q=8'h5C, owner=1, valid=1 throughout.
- Async reset mid-lock: assert reset between edges during a lock hold -> gnt, q and valid clear immediately. After release, arbitration restarts from index 0.
